// File: rtl/x_capture_driver.sv
// Host-side capture driver: decodes UART command bytes, snapshots delay-line channels
// (direct or through a FIFO) and streams the shift register out as bytes.
module x_capture_driver #(
  parameter int unsigned DL_W  = 32,
  parameter int unsigned CH    = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [7:0]           i_data,
  output logic                 o_valid,
  input  logic                 i_accept,
  output logic [7:0]           o_data,
  input  logic [CH*DL_W-1:0]   i_dl,
  output logic                 o_busy
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned NBytes = DL_W / 8;
  localparam int unsigned BcW    = $clog2(NBytes + 1);

  localparam logic [3:0] OpLoad   = 4'd0;
  localparam logic [3:0] OpUnload = 4'd1;
  localparam logic [3:0] OpSample = 4'd2;
  localparam logic [3:0] OpSnap   = 4'd3;
  localparam logic [3:0] OpPop    = 4'd4;
  localparam logic [3:0] OpStatus = 4'd5;

  typedef enum logic {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic [DL_W-1:0]   sr_q, sr_d;
  logic              valid_q, valid_d;
  logic [BcW-1:0]    bcnt_q, bcnt_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              push;

  logic [DL_W-1:0]   mem [DEPTH];

  logic [3:0]        op;
  logic [3:0]        payload;
  logic              ch_ok;
  logic [DL_W-1:0]   ch_sample;
  logic [DL_W-1:0]   status_word;

  assign op      = i_data[3:0];
  assign payload = i_data[7:4];
  assign ch_ok   = 32'(payload) < CH;

  always_comb begin
    ch_sample = '0;
    for (int k = 0; k < int'(CH); k++) begin
      if (payload == 4'(k)) ch_sample = i_dl[k*DL_W +: DL_W];
    end
  end

  always_comb begin
    status_word = '0;
    status_word[DL_W-1 -: 8] = {ovf_q, udf_q, 6'(cnt_q)};
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    valid_d  = valid_q;
    bcnt_d   = bcnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    push     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          case (op)
            OpLoad:   sr_d = {sr_q[DL_W-5:0], payload};
            OpUnload: begin
              bcnt_d  = BcW'(NBytes);
              valid_d = 1'b1;
              state_d = StSend;
            end
            OpSample: if (ch_ok) sr_d = ch_sample;
            OpSnap: begin
              if (ch_ok) begin
                if (cnt_q == CntW'(DEPTH)) begin
                  ovf_d = 1'b1;
                end else begin
                  push     = 1'b1;
                  wr_ptr_d = wr_ptr_q + PtrW'(1);
                  cnt_d    = cnt_q + CntW'(1);
                end
              end
            end
            OpPop: begin
              if (cnt_q == '0) begin
                udf_d = 1'b1;
              end else begin
                sr_d     = mem[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                cnt_d    = cnt_q - CntW'(1);
              end
            end
            OpStatus: begin
              sr_d  = status_word;
              ovf_d = 1'b0;
              udf_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      StSend: begin
        // Commands arriving here are dropped; only the TX handshake advances.
        if (valid_q && i_accept) begin
          sr_d   = sr_q << 8;
          bcnt_d = bcnt_q - BcW'(1);
          if (bcnt_q == BcW'(1)) begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      valid_q  <= 1'b0;
      bcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      valid_q  <= valid_d;
      bcnt_q   <= bcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Snapshot storage is deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= ch_sample;
  end

  assign o_valid = valid_q;
  assign o_busy  = (state_q == StSend);
  assign o_data  = sr_q[DL_W-1 -: 8];

endmodule

// File: tb/tb_x_capture_driver.sv
// Bench for x_capture_driver: command vector table, directed multi-cycle sequences and
// randomized commands checked against a queue-based reference model.
module tb_x_capture_driver;

  localparam int unsigned DL_W  = 32;
  localparam int unsigned CH    = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                 valid_a, accept_a, ovalid_a, busy_a;
  logic [7:0]           data_a, odata_a;
  logic [CH*DL_W-1:0]   dl_a;

  logic                 valid_b, accept_b, ovalid_b, busy_b;
  logic [7:0]           data_b, odata_b;
  logic [15:0]          dl_b;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] exp_top;
  } vec_t;

  vec_t vec [15];

  always #5 clk = ~clk;

  x_capture_driver #(.DL_W(32), .CH(4), .DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_a), .i_data(data_a), .o_valid(ovalid_a),
    .i_accept(accept_a), .o_data(odata_a), .i_dl(dl_a), .o_busy(busy_a)
  );

  x_capture_driver #(.DL_W(16), .CH(1), .DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_b), .i_data(data_b), .o_valid(ovalid_b),
    .i_accept(accept_b), .o_data(odata_b), .i_dl(dl_b), .o_busy(busy_b)
  );

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_a = 1'b0; accept_a = 1'b0; data_a = '0;
    valid_b = 1'b0; accept_b = 1'b0; data_b = '0;
    @(negedge clk);
    @(negedge clk);
    chk1("rst_valid", ovalid_a, 1'b0);
    chk1("rst_busy", busy_a, 1'b0);
    chk8("rst_data", odata_a, 8'h00);
    rst = 1'b0;
  endtask

  // Called and returns at a negedge; results are visible on return.
  task automatic cmd_a(input logic [7:0] b);
    valid_a = 1'b1;
    data_a  = b;
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic cmd_b(input logic [7:0] b);
    valid_b = 1'b1;
    data_b  = b;
    @(negedge clk);
    valid_b = 1'b0;
  endtask

  // mode 0: accept always, 1: accept every other cycle, 2: random accept.
  task automatic unload(input string name, input int mode, input int inj_at,
                        input logic [7:0] inj);
    int idx = 0;
    int cyc = 0;
    logic a;
    valid_a  = 1'b1;
    data_a   = 8'h01;
    accept_a = 1'b0;
    @(negedge clk);
    valid_a = 1'b0;
    while (idx < exp_q.size() && cyc < 200) begin
      chk1({name, "_valid"}, ovalid_a, 1'b1);
      chk1({name, "_busy"}, busy_a, 1'b1);
      chk8({name, "_byte"}, odata_a, exp_q[idx]);
      case (mode)
        0:       a = 1'b1;
        1:       a = (cyc % 2 == 1);
        default: a = 1'($urandom_range(0, 1));
      endcase
      if (cyc == inj_at) begin
        valid_a = 1'b1;
        data_a  = inj;
      end
      accept_a = a;
      @(negedge clk);
      valid_a = 1'b0;
      if (a) idx++;
      cyc++;
    end
    if (idx < exp_q.size()) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d bytes expected %0d", name, idx, exp_q.size());
    end
    accept_a = 1'b0;
    chk1({name, "_valid_end"}, ovalid_a, 1'b0);
    chk1({name, "_busy_end"}, busy_a, 1'b0);
    chk8({name, "_sr_empty"}, odata_a, 8'h00);
  endtask

  task automatic load_1_to_8();
    for (int k = 1; k <= 8; k++) cmd_a({4'(k), 4'h0});
  endtask

  // Reference model state (transaction level)
  logic [31:0] m_sr;
  logic [31:0] m_fifo[$];
  logic        m_ovf, m_udf;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dl_a = '0;
    dl_b = '0;
    valid_a = 1'b0; accept_a = 1'b0; data_a = '0;
    valid_b = 1'b0; accept_b = 1'b0; data_b = '0;

    // Vector table
    vec[0]  = '{8'h02, 8'h0A};
    vec[1]  = '{8'h32, 8'h55};
    vec[2]  = '{8'h22, 8'hDE};
    vec[3]  = '{8'h72, 8'hDE};
    vec[4]  = '{8'h50, 8'hEA};
    vec[5]  = '{8'hF0, 8'hAD};
    vec[6]  = '{8'h09, 8'hAD};
    vec[7]  = '{8'h12, 8'h11};
    vec[8]  = '{8'h05, 8'h00};
    vec[9]  = '{8'h03, 8'h00};
    vec[10] = '{8'h05, 8'h01};
    vec[11] = '{8'h04, 8'h0A};
    vec[12] = '{8'h04, 8'h0A};
    vec[13] = '{8'h05, 8'h40};
    vec[14] = '{8'h05, 8'h00};

    do_reset();
    dl_a = {32'h55667788, 32'hDEADBEEF, 32'h11223344, 32'h0A1B2C3D};
    for (int i = 0; i < 15; i++) begin
      cmd_a(vec[i].cmd);
      chk8($sformatf("vec%0d_top", i), odata_a, vec[i].exp_top);
      chk1($sformatf("vec%0d_busy", i), busy_a, 1'b0);
      chk1($sformatf("vec%0d_valid", i), ovalid_a, 1'b0);
    end

    // Load then unload with accept held high
    do_reset();
    load_1_to_8();
    exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    unload("unload_fast", 0, -1, 8'h00);

    // Sample then unload with toggling accept
    dl_a[2*32 +: 32] = 32'hDEADBEEF;
    cmd_a(8'h22);
    chk8("sample_ch2", odata_a, 8'hDE);
    exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    unload("unload_toggle", 1, -1, 8'h00);

    // FIFO overflow / underflow and status
    do_reset();
    for (int k = 0; k < 4; k++) begin
      dl_a[31:0] = {8'hA0 + 8'(k), 16'h0000, 8'(k)};
      cmd_a(8'h03);
    end
    cmd_a(8'h05);
    chk8("status_full", odata_a, 8'h04);
    dl_a[31:0] = 32'hA4000004;
    cmd_a(8'h03);
    for (int k = 0; k < 4; k++) begin
      cmd_a(8'h04);
      chk8($sformatf("pop%0d", k), odata_a, 8'hA0 + 8'(k));
    end
    cmd_a(8'h04);
    chk8("pop_empty", odata_a, 8'hA3);
    cmd_a(8'h05);
    chk8("status_flags", odata_a, 8'hC0);
    exp_q = '{8'hC0, 8'h00, 8'h00, 8'h00};
    unload("unload_status", 2, -1, 8'h00);
    cmd_a(8'h05);
    chk8("status_cleared", odata_a, 8'h00);

    // Command during SEND is dropped
    load_1_to_8();
    exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    unload("unload_inject", 0, 1, 8'h50);
    cmd_a(8'h05);
    chk8("status_after_inject", odata_a, 8'h00);

    // Reset mid-SEND
    dl_a[31:0] = 32'h12345678;
    cmd_a(8'h03);
    load_1_to_8();
    valid_a  = 1'b1;
    data_a   = 8'h01;
    accept_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk8("midsend_byte3", odata_a, 8'h56);
    chk1("midsend_valid", ovalid_a, 1'b1);
    accept_a = 1'b0;
    rst = 1'b1;
    #1;
    chk1("abort_valid", ovalid_a, 1'b0);
    chk1("abort_busy", busy_a, 1'b0);
    chk8("abort_data", odata_a, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    cmd_a(8'h05);
    chk8("abort_cnt", odata_a, 8'h00);

    // Narrow instance: DL_W=16, CH=1
    for (int k = 1; k <= 4; k++) cmd_b({4'(k), 4'h0});
    cmd_b(8'h12);
    chk8("b_sample_oob", odata_b, 8'h12);
    valid_b  = 1'b1;
    data_b   = 8'h01;
    accept_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
    chk1("b_valid0", ovalid_b, 1'b1);
    chk1("b_busy0", busy_b, 1'b1);
    chk8("b_byte0", odata_b, 8'h12);
    @(negedge clk);
    chk1("b_valid1", ovalid_b, 1'b1);
    chk8("b_byte1", odata_b, 8'h34);
    @(negedge clk);
    accept_b = 1'b0;
    chk1("b_valid_end", ovalid_b, 1'b0);
    chk1("b_busy_end", busy_b, 1'b0);
    dl_b = 16'hBEEF;
    cmd_b(8'h02);
    chk8("b_sample", odata_b, 8'hBE);

    // Randomized commands against the reference model
    do_reset();
    m_sr  = '0;
    m_fifo.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    for (int n = 0; n < 200; n++) begin
      logic [3:0]  op, p;
      logic [31:0] ch;
      op = 4'($urandom_range(0, 9));
      p  = 4'($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) dl_a[k*32 +: 32] = $urandom;
      ch = (p < 4'(CH)) ? dl_a[p*32 +: 32] : 32'h0;
      if (op == 4'd1) begin
        exp_q.delete();
        for (int k = 3; k >= 0; k--) exp_q.push_back(m_sr[k*8 +: 8]);
        m_sr = '0;
        unload("rnd_unload", 2, -1, 8'h00);
      end else begin
        cmd_a({p, op});
        case (op)
          4'd0: m_sr = {m_sr[27:0], p};
          4'd2: if (p < 4'(CH)) m_sr = ch;
          4'd3: begin
            if (p < 4'(CH)) begin
              if (m_fifo.size() == DEPTH) m_ovf = 1'b1;
              else m_fifo.push_back(ch);
            end
          end
          4'd4: begin
            if (m_fifo.size() == 0) m_udf = 1'b1;
            else m_sr = m_fifo.pop_front();
          end
          4'd5: begin
            m_sr  = {m_ovf, m_udf, 6'(m_fifo.size()), 24'h000000};
            m_ovf = 1'b0;
            m_udf = 1'b0;
          end
          default: ;
        endcase
        chk8("rnd_top", odata_a, m_sr[31:24]);
        chk1("rnd_busy", busy_a, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
